// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-side bundle between program counter logic, imem and the decode stage.
interface instr_fetch_if #(
  parameter int PC_W  = 10,
  parameter int IW    = 9,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic [PC_W-1:0]  ImemAddr;
  logic [IW-1:0]    ImemRdata;
  logic [IW-1:0]    Instr;
  logic             InstrValid;
  logic             InstrReady;
  logic [PC_W-1:0]  Pc;
  logic             BranchTaken;
  logic [PC_W-1:0]  BranchTarget;
  logic             Done;
  logic [CNT_W-1:0] RetireCnt;
  modport master (
    input  Start, StartAddr, ImemRdata, InstrReady, BranchTaken, BranchTarget,
    output ImemAddr, Instr, InstrValid, Pc, Done, RetireCnt
  );
  modport slave (
    output Start, StartAddr, ImemRdata, InstrReady, BranchTaken, BranchTarget,
    input  ImemAddr, Instr, InstrValid, Pc, Done, RetireCnt
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner feeding a sync-read imem and the decoder over valid/ready.
// Define BRANCH_REL_EN for PC-relative branch targets (absolute otherwise).
module instr_fetch #(
  parameter int PC_W  = 10,
  parameter int IW    = 9,
  parameter int CNT_W = 16
) (
  input logic          Clk,
  input logic          Reset,
  instr_fetch_if.master f
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, HALT} state_e;
  state_e           state_q;
  logic [PC_W-1:0]  pc_q, sa_q, tgt;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q, done_q, acc, halt, br;
  assign acc  = valid_q & f.InstrReady;
  assign halt = f.ImemRdata[IW-1:IW-5] == 5'b11111;
  assign br   = (state_q == RUN) & f.BranchTaken;
`ifdef BRANCH_REL_EN
  assign tgt = pc_q + f.BranchTarget;
`else
  assign tgt = f.BranchTarget;
`endif
  // Address is issued one cycle ahead of the instruction it returns.
  always_comb begin
    f.ImemAddr = Reset               ? '0 :
                 state_q == IDLE     ? (f.Start ? f.StartAddr : '0) :
                 state_q == FILL     ? sa_q :
                 br                  ? tgt :
                 (state_q == RUN && acc && !halt) ? pc_q + 1'b1 : pc_q;
  end
  assign f.Instr      = valid_q ? f.ImemRdata : '0;
  assign f.InstrValid = valid_q;
  assign f.Pc         = pc_q;
  assign f.Done       = done_q;
  assign f.RetireCnt  = cnt_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sa_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (acc && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
      case (state_q)
        IDLE, HALT: if (f.Start) begin
          sa_q    <= f.StartAddr;
          done_q  <= 1'b0;
          state_q <= FILL;
        end
        FILL: begin
          pc_q    <= sa_q;
          valid_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: if (f.BranchTaken) begin
          pc_q    <= tgt;
          valid_q <= 1'b0;
        end else if (!valid_q) begin
          valid_q <= 1'b1;
        end else if (acc && halt) begin
          valid_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= HALT;
        end else if (acc) begin
          pc_q <= pc_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random stimulus against a transaction-level fetch model.
module tb_instr_fetch;
  localparam int PC_W = 5, IW = 9, CNT_W = 4;
  localparam int DEPTH = 1 << PC_W, CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_if #(.PC_W(PC_W), .IW(IW), .CNT_W(CNT_W)) bus();
  instr_fetch #(.PC_W(PC_W), .IW(IW), .CNT_W(CNT_W)) dut (.Clk(clk), .Reset(rst), .f(bus));
  logic [IW-1:0] imem [DEPTH];
  always @(posedge clk) bus.ImemRdata <= imem[bus.ImemAddr];
  int n_checks = 0, n_errors = 0;
  bit m_run, m_valid, m_done;
  int m_pc, m_cnt, m_wait, m_sa;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(bit r, bit s, logic [PC_W-1:0] sa, bit rdy, bit b, logic [PC_W-1:0] bt);
    bit acc;
    int tgt;
    rst = r;
    bus.Start = s;
    bus.StartAddr = sa;
    bus.InstrReady = rdy;
    bus.BranchTaken = b;
    bus.BranchTarget = bt;
    #1;
    if (!r && m_run && m_valid && !rdy && !b) check("stall_addr", 32'(bus.ImemAddr), m_pc);
    if (!r && !m_run && !m_done && !s) check("idle_addr", 32'(bus.ImemAddr), 0);
`ifdef BRANCH_REL_EN
    tgt = (m_pc + int'(bt)) % DEPTH;
`else
    tgt = int'(bt);
`endif
    @(posedge clk);
    acc = m_valid && rdy;
    if (r) begin
      m_run = 0; m_valid = 0; m_done = 0; m_pc = 0; m_cnt = 0; m_wait = 0;
    end else if (!m_run) begin
      if (s) begin m_run = 1; m_done = 0; m_wait = 2; m_sa = int'(sa); end
    end else if (m_wait == 2) begin
      m_pc = m_sa; m_valid = 1; m_wait = 0;
    end else begin
      if (acc) m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
      if (b) begin
        m_pc = tgt; m_valid = 0; m_wait = 1;
      end else if (m_wait == 1) begin
        m_valid = 1; m_wait = 0;
      end else if (acc && imem[m_pc][8:4] == 5'h1f) begin
        m_run = 0; m_done = 1; m_valid = 0;
      end else if (acc) begin
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
    @(negedge clk);
    check("valid", 32'(bus.InstrValid), 32'(m_valid));
    check("done", 32'(bus.Done), 32'(m_done));
    check("pc", 32'(bus.Pc), m_pc);
    check("retire", 32'(bus.RetireCnt), m_cnt);
    check("instr", 32'(bus.Instr), m_valid ? 32'(imem[m_pc]) : 0);
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) imem[i] = IW'($urandom_range(0, 511));
    for (int i = 0; i < 6; i++) imem[i] = imem[i] & 9'h1ef;
    imem[0] = 9'h001; imem[1] = 9'h002; imem[2] = 9'h003; imem[3] = 9'h004;
    imem[6] = 9'h1f0;
    imem[30] = imem[30] & 9'h1ef;
    imem[31] = imem[31] & 9'h1ef;
    {bus.Start, bus.StartAddr, bus.InstrReady, bus.BranchTaken, bus.BranchTarget} = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 5'd0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 1, 5'd30, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 1, 5'd1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 5'd20);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0, PC_W'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, PC_W'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
